// File: rtl/prio_pkg.sv
// Shared types and constants for the sequential priority encoder.
// Optional macro PRIO_ROUND_ROBIN_EN (used by prio_encoder_seq) selects rotating priority.
package prio_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } prio_state_e;

endpackage

// File: rtl/prio_encoder_seq_if.sv
// Request/grant bus of the sequential priority encoder; the producer/consumer side is master,
// the encoder is slave. Optional macro PRIO_ROUND_ROBIN_EN does not change this interface.
interface prio_encoder_seq_if
    import prio_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = $clog2(N)
);

    logic [N-1:0] req;
    logic         out_ready;
    logic         ovf_clr;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         ovf;

    modport master (
        output req,
        output out_ready,
        output ovf_clr,
        input  out_valid,
        input  out_idx,
        input  pending,
        input  ovf
    );

    modport slave (
        input  req,
        input  out_ready,
        input  ovf_clr,
        output out_valid,
        output out_idx,
        output pending,
        output ovf
    );

endinterface

// File: rtl/prio_pick.sv
// Combinational search for the first set bit of i_vec, starting at i_start and descending
// with wrap from 0 to N-1. Independent of macro PRIO_ROUND_ROBIN_EN.
module prio_pick
    import prio_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W-1:0] w_probe;

    // The probe walks downward from the start position; the first hit is kept.
    always_comb begin
        o_idx   = '0;
        o_any   = 1'b0;
        w_probe = i_start;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_vec[w_probe]) begin
                o_idx = w_probe;
                o_any = 1'b1;
            end
            w_probe = (w_probe == '0) ? W'(N - 1) : w_probe - W'(1);
        end
    end

endmodule

// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: captures requests, presents one index at a time with valid/ready.
// Macro PRIO_ROUND_ROBIN_EN enables rotating priority; otherwise the highest index always wins.
module prio_encoder_seq
    import prio_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    prio_encoder_seq_if.slave   bus
);

    prio_state_e  r_state;
    prio_state_e  w_nextState;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_cand;
    logic [N-1:0] w_winMask;
    logic [W-1:0] r_outIdx;
    logic [W-1:0] w_winIdx;
    logic [W-1:0] w_start;
    logic         w_any;
    logic         w_load;
    logic         w_outValid;
    logic         r_ovf;

    assign w_cand    = r_pending | bus.req;
    assign w_winMask = N'(1) << w_winIdx;
    assign w_load    = w_any && ((r_state == EMPTY) || bus.out_ready);

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .i_vec   (w_cand),
        .i_start (w_start),
        .o_idx   (w_winIdx),
        .o_any   (w_any)
    );

`ifdef PRIO_ROUND_ROBIN_EN
    logic [W-1:0] r_ptr;

    // After granting k the next search starts just below k, wrapping to the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= W'(N - 1);
        end else if (w_load) begin
            r_ptr <= (w_winIdx == '0) ? W'(N - 1) : w_winIdx - W'(1);
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = W'(N - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: if (w_any) w_nextState = HOLD;
            HOLD:  if (bus.out_ready && !w_any) w_nextState = EMPTY;
        endcase
    end

    always_comb begin
        w_outValid = (r_state == HOLD);
    end

    // Pending always absorbs the candidate set; only a fresh grant removes its own bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outIdx  <= '0;
            r_pending <= '0;
        end else if (w_load) begin
            r_outIdx  <= w_winIdx;
            r_pending <= w_cand & ~w_winMask;
        end else begin
            r_pending <= w_cand;
        end
    end

    // A new repeat request outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((bus.req & r_pending) != '0) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.out_valid = w_outValid;
    assign bus.out_idx   = r_outIdx;
    assign bus.pending   = r_pending;
    assign bus.ovf       = r_ovf;

endmodule
